// File: rtl/channel_arbiter_fsm_if.sv
// rtl/channel_arbiter_fsm_if.sv - request/grant bundle between channel sources and the arbiter
interface channel_arbiter_fsm_if #(
    parameter int N_CH   = 16,
    parameter int HOLD_W = 8
);
    localparam int IDX_W = $clog2(N_CH);

    logic              en_i;
    logic              mode_i;
    logic [N_CH-1:0]   req_i;
    logic              done_i;
    logic [HOLD_W-1:0] max_hold_i;
    logic [N_CH-1:0]   gnt_o;
    logic [IDX_W-1:0]  gnt_idx_o;
    logic              gnt_vld_o;
    logic              timeout_o;

    modport slave (
        input  en_i, mode_i, req_i, done_i, max_hold_i,
        output gnt_o, gnt_idx_o, gnt_vld_o, timeout_o
    );

    modport master (
        output en_i, mode_i, req_i, done_i, max_hold_i,
        input  gnt_o, gnt_idx_o, gnt_vld_o, timeout_o
    );
endinterface

// File: rtl/channel_arbiter_fsm.sv
// rtl/channel_arbiter_fsm.sv - held, time-bounded fixed-priority / round-robin channel arbiter
module channel_arbiter_fsm #(
    parameter int N_CH   = 16,
    parameter int HOLD_W = 8
) (
    input logic                  clk_i,
    input logic                  rst_i,
    channel_arbiter_fsm_if.slave bus
);
    localparam int IDX_W = $clog2(N_CH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e            state_q;
    logic [N_CH-1:0]   gnt_q;
    logic [IDX_W-1:0]  gnt_idx_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic              gnt_vld_q;
    logic              timeout_q;
    logic [HOLD_W-1:0] hold_q;

    logic              win_vld_d;
    logic [IDX_W-1:0]  win_idx_d;
    logic [N_CH-1:0]   win_gnt_d;

    // Fixed priority is round-robin with the search base pinned at 0; scanning
    // downward lets the closest hit above the base overwrite farther ones.
    always_comb begin
        int               base;
        int               c;
        logic [IDX_W-1:0] c_idx;
        win_vld_d = 1'b0;
        win_idx_d = '0;
        c         = 0;
        c_idx     = '0;
        base      = bus.mode_i ? int'(rr_ptr_q) : 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            c = base + k;
            if (c >= N_CH) begin
                c = c - N_CH;
            end
            c_idx = IDX_W'(c);
            if (bus.req_i[c_idx]) begin
                win_vld_d = 1'b1;
                win_idx_d = c_idx;
            end
        end
    end

    assign win_gnt_d = {{(N_CH - 1){1'b0}}, 1'b1} << win_idx_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            rr_ptr_q  <= '0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (bus.en_i && win_vld_d) begin
                        gnt_q     <= win_gnt_d;
                        gnt_idx_q <= win_idx_d;
                        gnt_vld_q <= 1'b1;
                        hold_q    <= HOLD_W'(1);
                        state_q   <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.done_i || !bus.req_i[gnt_idx_q]) begin
                        gnt_q     <= '0;
                        gnt_vld_q <= 1'b0;
                        state_q   <= RELEASE;
                    end else if (bus.max_hold_i != '0 && hold_q == bus.max_hold_i) begin
                        gnt_q     <= '0;
                        gnt_vld_q <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= RELEASE;
                    end else if (hold_q != '1) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                RELEASE: begin
                    timeout_q <= 1'b0;
                    // Wrap at N_CH, not at the index width, for non-power-of-two counts.
                    rr_ptr_q  <= (gnt_idx_q == IDX_W'(N_CH - 1)) ? '0 : gnt_idx_q + 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.gnt_idx_o = gnt_idx_q;
    assign bus.gnt_vld_o = gnt_vld_q;
    assign bus.timeout_o = timeout_q;
endmodule

// File: tb/tb_channel_arbiter_fsm.sv
// tb/tb_channel_arbiter_fsm.sv - directed self-checking bench for channel_arbiter_fsm
module tb_channel_arbiter_fsm;
    localparam int N_CH   = 16;
    localparam int HOLD_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    channel_arbiter_fsm_if #(.N_CH(N_CH), .HOLD_W(HOLD_W)) bus ();

    channel_arbiter_fsm #(.N_CH(N_CH), .HOLD_W(HOLD_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst            = 1'b1;
        bus.en_i       = 1'b0;
        bus.mode_i     = 1'b0;
        bus.req_i      = '0;
        bus.done_i     = 1'b0;
        bus.max_hold_i = '0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic wait_grant(output bit seen);
        int n = 0;
        while (bus.gnt_vld_o !== 1'b1 && n < 8) begin
            cyc();
            n++;
        end
        seen = (bus.gnt_vld_o === 1'b1);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.en_i       = 1'b1;
        bus.mode_i     = 1'b0;
        bus.req_i      = 16'hFFFF;
        bus.done_i     = 1'b0;
        bus.max_hold_i = 8'd0;
        cyc(2);
        vectors++;
        if (bus.gnt_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_gnt: got %h want 0000", bus.gnt_o);
        end
        vectors++;
        if (bus.gnt_idx_o !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_idx: got %0d want 0", bus.gnt_idx_o);
        end
        vectors++;
        if (bus.gnt_vld_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_vld_timeout: got vld=%b to=%b want 0 0", bus.gnt_vld_o, bus.timeout_o);
        end
    endtask

    task automatic test_fixed_priority();
        reset_dut();
        bus.mode_i = 1'b0;
        bus.en_i   = 1'b1;
        bus.req_i  = 16'h00A4;
        cyc();
        for (int i = 1; i <= 3; i++) begin
            vectors++;
            if (bus.gnt_vld_o !== 1'b1 || bus.gnt_idx_o !== 4'd2 || bus.gnt_o !== 16'h0004) begin
                miscompares++;
                $display("FAIL fixed_grant_c%0d: got vld=%b idx=%0d gnt=%h want 1 2 0004",
                         i, bus.gnt_vld_o, bus.gnt_idx_o, bus.gnt_o);
            end
            if (i == 3) bus.done_i = 1'b1;
            cyc();
        end
        bus.done_i = 1'b0;
        vectors++;
        if (bus.gnt_vld_o !== 1'b0 || bus.gnt_o !== 16'h0000 || bus.timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fixed_release: got vld=%b gnt=%h to=%b want 0 0000 0",
                     bus.gnt_vld_o, bus.gnt_o, bus.timeout_o);
        end
        cyc();
        vectors++;
        if (bus.gnt_vld_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fixed_gap: got vld=%b want 0", bus.gnt_vld_o);
        end
        cyc();
        vectors++;
        if (bus.gnt_vld_o !== 1'b1 || bus.gnt_idx_o !== 4'd2) begin
            miscompares++;
            $display("FAIL fixed_regrant: got vld=%b idx=%0d want 1 2", bus.gnt_vld_o, bus.gnt_idx_o);
        end
    endtask

    task automatic test_round_robin();
        int         exp_q [6] = '{0, 1, 15, 0, 1, 15};
        logic [15:0] want;
        bit          seen;
        reset_dut();
        bus.mode_i = 1'b1;
        bus.en_i   = 1'b1;
        bus.req_i  = 16'h8003;
        for (int g = 0; g < 6; g++) begin
            wait_grant(seen);
            want = 16'h0001 << exp_q[g];
            vectors++;
            if (!seen || bus.gnt_idx_o !== 4'(exp_q[g]) || bus.gnt_o !== want) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: got vld=%b idx=%0d gnt=%h want 1 %0d %h",
                         g, bus.gnt_vld_o, bus.gnt_idx_o, bus.gnt_o, exp_q[g], want);
            end
            bus.done_i = 1'b1;
            cyc();
            bus.done_i = 1'b0;
            vectors++;
            if (bus.gnt_vld_o !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_release_%0d: got vld=%b want 0", g, bus.gnt_vld_o);
            end
        end
    endtask

    task automatic test_hold_timeout();
        reset_dut();
        bus.mode_i     = 1'b0;
        bus.en_i       = 1'b1;
        bus.max_hold_i = 8'd4;
        bus.req_i      = 16'h0008;
        cyc();
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (bus.gnt_vld_o !== 1'b1 || bus.gnt_idx_o !== 4'd3 || bus.timeout_o !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_c%0d: got vld=%b idx=%0d to=%b want 1 3 0",
                         i, bus.gnt_vld_o, bus.gnt_idx_o, bus.timeout_o);
            end
            cyc();
        end
        vectors++;
        if (bus.gnt_vld_o !== 1'b0 || bus.timeout_o !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: got vld=%b to=%b want 0 1", bus.gnt_vld_o, bus.timeout_o);
        end
        cyc();
        vectors++;
        if (bus.gnt_vld_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_idle: got vld=%b to=%b want 0 0", bus.gnt_vld_o, bus.timeout_o);
        end
        cyc();
        vectors++;
        if (bus.gnt_vld_o !== 1'b1 || bus.gnt_idx_o !== 4'd3) begin
            miscompares++;
            $display("FAIL hold_regrant: got vld=%b idx=%0d want 1 3", bus.gnt_vld_o, bus.gnt_idx_o);
        end
    endtask

    task automatic test_simultaneous();
        reset_dut();
        bus.mode_i     = 1'b0;
        bus.en_i       = 1'b1;
        bus.max_hold_i = 8'd2;
        bus.req_i      = 16'h0020;
        cyc(2);
        bus.done_i = 1'b1;
        cyc();
        bus.done_i = 1'b0;
        vectors++;
        if (bus.gnt_vld_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_done_at_limit: got vld=%b to=%b want 0 0", bus.gnt_vld_o, bus.timeout_o);
        end
        cyc(2);
        vectors++;
        if (bus.gnt_vld_o !== 1'b1 || bus.gnt_idx_o !== 4'd5) begin
            miscompares++;
            $display("FAIL sim_regrant: got vld=%b idx=%0d want 1 5", bus.gnt_vld_o, bus.gnt_idx_o);
        end
        cyc();
        bus.req_i = 16'h0000;
        cyc();
        vectors++;
        if (bus.gnt_vld_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_req_drop: got vld=%b to=%b want 0 0", bus.gnt_vld_o, bus.timeout_o);
        end
    endtask

    task automatic test_enable_idle();
        bit any;
        reset_dut();
        bus.mode_i = 1'b0;
        bus.en_i   = 1'b0;
        bus.req_i  = 16'hFFFF;
        any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.gnt_vld_o !== 1'b0 || bus.gnt_o !== 16'h0000) any = 1'b1;
        end
        vectors++;
        if (any) begin
            miscompares++;
            $display("FAIL en_low_no_grant: got a grant want none");
        end
        bus.en_i = 1'b1;
        cyc();
        bus.en_i = 1'b0;
        cyc(3);
        vectors++;
        if (bus.gnt_vld_o !== 1'b1 || bus.gnt_idx_o !== 4'd0 || bus.gnt_o !== 16'h0001) begin
            miscompares++;
            $display("FAIL en_drop_hold: got vld=%b idx=%0d gnt=%h want 1 0 0001",
                     bus.gnt_vld_o, bus.gnt_idx_o, bus.gnt_o);
        end
        bus.done_i = 1'b1;
        cyc();
        bus.done_i = 1'b0;
        any = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.gnt_vld_o !== 1'b0) any = 1'b1;
            cyc();
        end
        vectors++;
        if (any) begin
            miscompares++;
            $display("FAIL en_drop_no_regrant: got a grant want none");
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        reset_dut();
        bus.mode_i = 1'b1;
        bus.en_i   = 1'b1;
        bus.req_i  = 16'h0010;
        cyc();
        bus.done_i = 1'b1;
        cyc();
        bus.done_i = 1'b0;
        bus.req_i  = 16'h0200;
        wait_grant(seen);
        vectors++;
        if (!seen || bus.gnt_idx_o !== 4'd9) begin
            miscompares++;
            $display("FAIL areset_pre_grant: got vld=%b idx=%0d want 1 9", bus.gnt_vld_o, bus.gnt_idx_o);
        end
        cyc();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.gnt_o !== 16'h0000 || bus.gnt_idx_o !== 4'd0 ||
            bus.gnt_vld_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_immediate: got gnt=%h idx=%0d vld=%b to=%b want 0000 0 0 0",
                     bus.gnt_o, bus.gnt_idx_o, bus.gnt_vld_o, bus.timeout_o);
        end
        bus.mode_i = 1'b1;
        bus.req_i  = 16'hFFFF;
        #2;
        rst = 1'b0;
        wait_grant(seen);
        vectors++;
        if (!seen || bus.gnt_idx_o !== 4'd0) begin
            miscompares++;
            $display("FAIL areset_rr_restart: got vld=%b idx=%0d want 1 0", bus.gnt_vld_o, bus.gnt_idx_o);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_hold_timeout();
        test_simultaneous();
        test_enable_idle();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/channel_arbiter_fsm.md
# channel_arbiter_fsm

Parametrised request arbiter that grants exclusive access to one of N_CH channels at a time, with selectable fixed-priority or round-robin arbitration. Holds each grant until the owner signals completion, drops its request, or exceeds a programmable hold limit. Sits between the per-channel request sources and the shared encoder datapath, replacing single-shot channel selection with a held, fair, time-bounded grant.

## Interface
- N_CH, 16, number of channels; N_CH >= 2, not required to be a power of two
- HOLD_W, 8, width of the hold-limit counter and of max_hold_i
- IDX_W (derived), $clog2(N_CH), width of gnt_idx_o

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  enables new grants; sampled only in IDLE
- mode_i  in  1  0 = fixed priority (lowest index wins), 1 = round-robin; sampled only in IDLE
- req_i  in  N_CH  per-channel request, level
- done_i  in  1  owner completion, single-cycle pulse, valid only in GRANT
- max_hold_i  in  HOLD_W  maximum grant length in cycles; 0 = unlimited
- gnt_o  out  N_CH  one-hot grant, registered
- gnt_idx_o  out  IDX_W  binary index of granted channel, registered
- gnt_vld_o  out  1  high while in GRANT
- timeout_o  out  1  one-cycle pulse when a grant was revoked by the hold limit

## Operation
- States: IDLE, GRANT, RELEASE. Reset state IDLE.
- IDLE: if en_i && |req_i, select winner, load gnt_o/gnt_idx_o, clear hold counter to 1, go to GRANT; else stay.
- Fixed mode: winner = lowest set index of req_i.
- Round-robin mode: winner = first set index at or above rr_ptr, searching upward and wrapping N_CH-1 -> 0.
- GRANT: gnt_o/gnt_idx_o stable. Exit to RELEASE on the first of these, evaluated in priority order:
  - done_i = 1: normal release, no timeout.
  - req_i[gnt_idx_o] = 0: abandoned release, no timeout.
  - max_hold_i != 0 && hold_cnt == max_hold_i: forced release, timeout_o = 1 in the following RELEASE cycle.
  - Otherwise hold_cnt increments, saturating at 2^HOLD_W-1.
- en_i low during GRANT does not revoke the current grant.
- RELEASE: gnt_o = 0, gnt_vld_o = 0; rr_ptr <= (gnt_idx_o == N_CH-1) ? 0 : gnt_idx_o+1; go to IDLE.
  - rr_ptr updates in both modes.
  - Wrap is computed modulo N_CH, never modulo 2^IDX_W.
- max_hold_i is compared live each GRANT cycle. Lowering it below the current hold_cnt does not trigger a timeout until the saturating counter matches again; software programs it only while idle.

## Timing
- Reset values: gnt_o = 0, gnt_idx_o = 0, gnt_vld_o = 0, timeout_o = 0, rr_ptr = 0, hold_cnt = 0. Assertion of rst_i clears all of these immediately, including mid-grant.
- Grant latency: request sampled at edge k in IDLE gives gnt_o valid after edge k (one cycle).
- Grant length with max_hold_i = M: exactly M cycles of gnt_vld_o, then one RELEASE cycle with timeout_o = 1.
- done_i or request drop at cycle c of GRANT: gnt_vld_o low from cycle c+1.
- Re-grant gap: minimum 2 cycles with gnt_vld_o = 0 (RELEASE, then IDLE arbitration).
- gnt_o is always one-hot or zero and is never changed while gnt_vld_o = 1.

## Test plan
- Fixed priority: mode_i=0, en_i=1, req_i=16'h00A4 held, done_i pulsed on the 3rd grant cycle -> gnt_idx_o=2 for 3 cycles, 2-cycle gap, gnt_idx_o=2 again (starvation of 5 and 7 expected).
- Round-robin fairness: mode_i=1, req_i=16'h8003, done_i after 1 cycle each grant -> grant order 0, 1, 15, 0, 1, 15 with rr_ptr wrapping 15 -> 0.
- Hold timeout: max_hold_i=4, req_i[3] held, no done_i -> gnt_vld_o high exactly 4 cycles, timeout_o=1 for 1 cycle in RELEASE, then re-grant to channel 3.
- Simultaneous events: done_i=1 on the same cycle hold_cnt==max_hold_i -> release with timeout_o=0. Request drop at cycle 2 -> release, timeout_o=0.
- Enable/idle: en_i=0 with req_i=16'hFFFF -> no grant ever. en_i dropped mid-grant -> grant continues until done_i, no new grant afterward.
- Async reset mid-grant: assert rst_i between edges during GRANT on channel 9 -> all outputs 0 immediately. After release with mode_i=1 and req_i=16'hFFFF -> first grant is channel 0.
